// File: rtl/s2p_rx_if.sv
// Bus bundle between a P2S transmitter side (master) and the s2p_rx receiver (slave).
interface s2p_rx_if #(
  parameter int unsigned DATA_BITS       = 64,
  parameter int unsigned DATA_COUNT_BITS = 6
);
  logic                     s_clk;
  logic                     s_clrn;
  logic                     s_sout;
  logic                     s_pen;
  logic [DATA_BITS-1:0]     data_out;
  logic                     data_valid;
  logic                     frame_err;
  logic                     busy;
  logic [DATA_COUNT_BITS:0] bit_cnt;

  modport master (
    output s_clk, s_clrn, s_sout, s_pen,
    input  data_out, data_valid, frame_err, busy, bit_cnt
  );

  modport slave (
    input  s_clk, s_clrn, s_sout, s_pen,
    output data_out, data_valid, frame_err, busy, bit_cnt
  );
endinterface

// File: rtl/s2p_rx.sv
// Serial-to-parallel frame receiver: synchronizes an async P2S link and latches full frames.
// Optional watchdog included when S2P_TIMEOUT_EN is defined.
module s2p_rx #(
  parameter int unsigned DATA_BITS       = 64,
  parameter int unsigned DATA_COUNT_BITS = 6,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic     clk,
  input  logic     rst,
  s2p_rx_if.slave  bus
);
  localparam int unsigned CW = DATA_COUNT_BITS + 1;

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_sclk_sync, r_sout_sync, r_pen_sync, r_clrn_sync;
  logic [DATA_BITS-1:0] r_shift, r_data_out;
  logic [CW-1:0]        r_bit_cnt;
  logic                 r_data_valid, r_frame_err;

  logic                 w_sclk_rise, w_pen_rise, w_clr, w_timeout;
  logic                 w_load, w_err;
  logic [DATA_BITS-1:0] w_shift_base, w_shift_nxt;
  logic [CW-1:0]        w_cnt_base, w_cnt_nxt;

  // Bits [1:0] synchronize, bit [2] is the edge-detect history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= 3'b000;
      r_sout_sync <= 3'b000;
      r_pen_sync  <= 3'b000;
      r_clrn_sync <= 3'b111;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], bus.s_clk};
      r_sout_sync <= {r_sout_sync[1:0], bus.s_sout};
      r_pen_sync  <= {r_pen_sync[1:0],  bus.s_pen};
      r_clrn_sync <= {r_clrn_sync[1:0], bus.s_clrn};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_pen_rise  = r_pen_sync[1]  & ~r_pen_sync[2];
  assign w_clr       = ~r_clrn_sync[1];

  // In IDLE the chain restarts from zero, so a frame never inherits stale bits.
  assign w_shift_base = (r_state == S_SHIFT) ? r_shift   : '0;
  assign w_cnt_base   = (r_state == S_SHIFT) ? r_bit_cnt : '0;
  assign w_shift_nxt  = w_sclk_rise ? {w_shift_base[DATA_BITS-2:0], r_sout_sync[1]} : w_shift_base;
  assign w_cnt_nxt    = (w_sclk_rise && (w_cnt_base < CW'(DATA_BITS + 1)))
                        ? (w_cnt_base + CW'(1)) : w_cnt_base;

`ifdef S2P_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_clr || (r_state != S_SHIFT) || w_sclk_rise) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TW'(TIMEOUT_CYCLES - 1)) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign w_timeout = (r_state == S_SHIFT) && !w_sclk_rise &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; clear dominates everything.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_sclk_rise) w_state_nxt = S_SHIFT;
        S_SHIFT: if (w_pen_rise || w_timeout) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame decision: the length check sees the count after any same-cycle shift.
  always_comb begin
    w_load = 1'b0;
    w_err  = 1'b0;
    if (!w_clr && (r_state == S_SHIFT)) begin
      if (w_pen_rise) begin
        if (w_cnt_nxt == CW'(DATA_BITS)) w_load = 1'b1;
        else                             w_err  = 1'b1;
      end else if (w_timeout) begin
        w_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= w_load;
      r_frame_err  <= w_err;
      if (w_load) r_data_out <= w_shift_nxt;
      if (w_clr) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= w_cnt_nxt;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = (r_state == S_SHIFT);
  assign bus.bit_cnt    = r_bit_cnt;

  logic w_unused_ok;
  assign w_unused_ok = ^{r_sout_sync[2], r_clrn_sync[2], 32'(TIMEOUT_CYCLES)};
endmodule

// File: tb/tb_s2p_rx.sv
// Directed bench for s2p_rx; watchdog case selected by S2P_TIMEOUT_EN (TIMEOUT_CYCLES = 16).
module tb_s2p_rx;
  localparam int unsigned DB = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  s2p_rx_if #(.DATA_BITS(DB), .DATA_COUNT_BITS(6)) bus ();

  s2p_rx #(
    .DATA_BITS      (DB),
    .DATA_COUNT_BITS(6),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_both   = 0;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) n_valid++;
    if (bus.frame_err  === 1'b1) n_err++;
    if ((bus.data_valid === 1'b1) && (bus.frame_err === 1'b1)) n_both++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_err   = 0;
  endtask

  task automatic send_bit(input logic b);
    bus.s_sout = b;
    tick(2);
    bus.s_clk = 1'b1;
    tick(3);
    bus.s_clk = 1'b0;
    tick(3);
  endtask

  // Sends the top n bits of w, MSB first.
  task automatic send_word(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[63-i]);
  endtask

  task automatic latch();
    bus.s_pen = 1'b1;
    tick(6);
    bus.s_pen = 1'b0;
    tick(4);
  endtask

  logic [63:0] w1, w4, w5;

  initial begin
    w1 = 64'h0123_4567_89AB_CDEF;
    w4 = 64'hFFFF_0000_FFFF_0000;
    w5 = 64'hDEAD_BEEF_CAFE_F00D;
    bus.s_clk  = 1'b0;
    bus.s_clrn = 1'b1;
    bus.s_sout = 1'b0;
    bus.s_pen  = 1'b0;
    rst = 1'b1;
    tick(4);
    chk("rst_data",  64'(bus.data_out),   64'd0);
    chk("rst_valid", 64'(bus.data_valid), 64'd0);
    chk("rst_err",   64'(bus.frame_err),  64'd0);
    chk("rst_busy",  64'(bus.busy),       64'd0);
    chk("rst_cnt",   64'(bus.bit_cnt),    64'd0);
    rst = 1'b0;
    tick(3);

    // Full 64-bit frame.
    clear_counts();
    send_word(w1, 64);
    chk("t1_cnt",   64'(bus.bit_cnt), 64'd64);
    chk("t1_busy",  64'(bus.busy),    64'd1);
    latch();
    chk("t1_valid", 64'(n_valid),      64'd1);
    chk("t1_err",   64'(n_err),        64'd0);
    chk("t1_data",  bus.data_out,      w1);
    chk("t1_cnt0",  64'(bus.bit_cnt),  64'd0);
    chk("t1_idle",  64'(bus.busy),     64'd0);

    // Latch strobe while idle is ignored.
    clear_counts();
    latch();
    chk("idle_valid", 64'(n_valid), 64'd0);
    chk("idle_err",   64'(n_err),   64'd0);
    chk("idle_data",  bus.data_out, w1);

    // Short frame.
    clear_counts();
    send_word(64'hAAAA_AAAA_AAAA_AAAA, 63);
    chk("t2_cnt", 64'(bus.bit_cnt), 64'd63);
    latch();
    chk("t2_err",   64'(n_err),   64'd1);
    chk("t2_valid", 64'(n_valid), 64'd0);
    chk("t2_data",  bus.data_out, w1);

    // Overrun frame, counter saturates at 65.
    clear_counts();
    send_word(64'h5555_5555_5555_5555, 64);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t3_sat", 64'(bus.bit_cnt), 64'd65);
    latch();
    chk("t3_err",   64'(n_err),   64'd1);
    chk("t3_valid", 64'(n_valid), 64'd0);
    chk("t3_data",  bus.data_out, w1);

    // Chain clear mid-frame, then a clean frame.
    clear_counts();
    send_word(64'h1234_5678_9ABC_DEF0, 30);
    chk("t4_cnt30", 64'(bus.bit_cnt), 64'd30);
    bus.s_clrn = 1'b0;
    tick(5);
    chk("t4_clr_cnt",  64'(bus.bit_cnt), 64'd0);
    chk("t4_clr_busy", 64'(bus.busy),    64'd0);
    bus.s_clrn = 1'b1;
    tick(4);
    send_word(w4, 64);
    latch();
    chk("t4_valid", 64'(n_valid), 64'd1);
    chk("t4_err",   64'(n_err),   64'd0);
    chk("t4_data",  bus.data_out, w4);

    // 64th shift and latch strobe in the same cycle.
    clear_counts();
    send_word(w5, 63);
    bus.s_sout = w5[0];
    tick(2);
    bus.s_clk = 1'b1;
    bus.s_pen = 1'b1;
    tick(6);
    bus.s_clk = 1'b0;
    bus.s_pen = 1'b0;
    tick(4);
    chk("t5_valid", 64'(n_valid), 64'd1);
    chk("t5_err",   64'(n_err),   64'd0);
    chk("t5_data",  bus.data_out, w5);

    // Reset mid-frame discards silently.
    clear_counts();
    send_word(w1, 20);
    rst = 1'b1;
    tick(3);
    chk("t6_data", bus.data_out,      64'd0);
    chk("t6_cnt",  64'(bus.bit_cnt),  64'd0);
    chk("t6_busy", 64'(bus.busy),     64'd0);
    rst = 1'b0;
    tick(3);
    chk("t6_valid", 64'(n_valid), 64'd0);
    chk("t6_err",   64'(n_err),   64'd0);

    // Stalled serial clock.
    clear_counts();
    send_word(w1, 10);
    tick(20);
`ifdef S2P_TIMEOUT_EN
    chk("t7_to_err",   64'(n_err),   64'd1);
    chk("t7_to_valid", 64'(n_valid), 64'd0);
    chk("t7_to_busy",  64'(bus.busy), 64'd0);
    chk("t7_to_data",  bus.data_out, 64'd0);
    clear_counts();
    latch();
    chk("t7_late_err",   64'(n_err),   64'd0);
    chk("t7_late_valid", 64'(n_valid), 64'd0);
`else
    chk("t7_hold_busy", 64'(bus.busy),    64'd1);
    chk("t7_hold_err",  64'(n_err),       64'd0);
    chk("t7_hold_cnt",  64'(bus.bit_cnt), 64'd10);
    latch();
    chk("t7_short_err",   64'(n_err),   64'd1);
    chk("t7_short_valid", 64'(n_valid), 64'd0);
`endif

    chk("excl", 64'(n_both), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/s2p_rx.md
S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 Parameter DATA_BITS, default 64, SHALL set the received frame width in bits.
REQ-002 Parameter DATA_COUNT_BITS, default 6, SHALL satisfy 2^DATA_COUNT_BITS = DATA_BITS; the bit counter SHALL be DATA_COUNT_BITS+1 wide.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the watchdog limit in clk cycles; it is used only when S2P_TIMEOUT_EN is defined.
REQ-004 clk  input  1  SHALL be the single system clock; all logic is rising-edge triggered.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 s_clk  input  1  SHALL be the asynchronous serial shift clock from a P2S transmitter.
REQ-007 s_clrn  input  1  SHALL be the asynchronous active-low serial chain clear.
REQ-008 s_sout  input  1  SHALL be the asynchronous serial data line, MSB first.
REQ-009 s_pen  input  1  SHALL be the asynchronous latch/parallel-enable strobe; a rising edge ends a frame.
REQ-010 data_out  output  DATA_BITS  SHALL carry the last valid received frame.
REQ-011 data_valid  output  1  SHALL be a one-cycle pulse marking a data_out update.
REQ-012 frame_err  output  1  SHALL be a one-cycle pulse marking a rejected frame.
REQ-013 busy  output  1  SHALL be high while the state is SHIFT.
REQ-014 bit_cnt  output  DATA_COUNT_BITS+1  SHALL report the bits shifted in the current frame.

Function
REQ-015 s_clk, s_clrn, s_sout and s_pen SHALL each pass through a 2-flop synchronizer and then a third flop used for edge detection.
REQ-016 A s_clk rise SHALL be detected when synchronizer stage 2 = 1 and stage 3 = 0; an s_pen rise SHALL be detected the same way.
REQ-017 On each s_clk rise, shift_reg SHALL become {shift_reg[DATA_BITS-2:0], synchronized s_sout}, and bit_cnt SHALL increment, saturating at DATA_BITS+1.
REQ-018 The state machine SHALL have two states, IDLE and SHIFT: IDLE goes to SHIFT on the first s_clk rise, and SHIFT goes to IDLE on an s_pen rise or on a clear.
REQ-019 On an s_pen rise in SHIFT with bit_cnt = DATA_BITS, data_out SHALL load shift_reg and data_valid SHALL pulse.
REQ-020 On an s_pen rise in SHIFT with bit_cnt != DATA_BITS (short or overrun), frame_err SHALL pulse and data_out SHALL hold.
REQ-021 On an s_pen rise in IDLE, no output SHALL change and no pulse SHALL occur.
REQ-022 The s_pen rise SHALL be detected by the edge-detection flop no earlier than clk edge k+2, where k is the clk edge that first samples s_pen = 1.
REQ-023 data_valid or frame_err SHALL be registered at the clk edge on which that s_pen rise is detected.
REQ-024 If an s_clk rise and an s_pen rise are detected in the same cycle, the shift SHALL apply first, and the count check SHALL use the updated bit_cnt.
REQ-025 A synchronized s_clrn = 0 SHALL clear shift_reg and bit_cnt and force IDLE, with priority over shift and latch, and SHALL produce no pulse.
REQ-026 On every return to IDLE, bit_cnt and shift_reg SHALL clear on the following clk edge.
REQ-027 data_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-028 rst SHALL have priority over all other inputs.
REQ-029 While rst is high, data_out SHALL be 0, data_valid 0, frame_err 0, busy 0, bit_cnt 0, shift_reg 0, and the state IDLE.
REQ-030 While rst is high, all synchronizer flops SHALL reset: s_clrn stages to 1 and all others to 0.
REQ-031 A rst asserted mid-frame SHALL discard that frame without a pulse.

Configuration
REQ-032 The macro S2P_TIMEOUT_EN SHALL select watchdog inclusion.
REQ-033 With S2P_TIMEOUT_EN defined, a counter SHALL run in SHIFT, clearing on each s_clk rise.
REQ-034 With S2P_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without an s_clk rise, frame_err SHALL pulse, the state SHALL go to IDLE, and data_out SHALL hold.
REQ-035 Without S2P_TIMEOUT_EN, no watchdog logic SHALL exist, and SHIFT SHALL persist indefinitely.

Verification
REQ-036 The bench SHALL check: 64 s_clk pulses carrying 64'h0123_4567_89AB_CDEF (MSB first), then an s_pen rise -> one data_valid pulse, data_out = 64'h0123_4567_89AB_CDEF, bit_cnt back to 0.
REQ-037 The bench SHALL check: 63 pulses then an s_pen rise -> one frame_err pulse, data_out unchanged from the prior frame.
REQ-038 The bench SHALL check: 66 pulses then an s_pen rise -> one frame_err pulse; bit_cnt reads 65 (saturated) before the latch.
REQ-039 The bench SHALL check: s_clrn low after 30 pulses, then 64 pulses of 64'hFFFF_0000_FFFF_0000 and an s_pen rise -> data_valid, data_out = 64'hFFFF_0000_FFFF_0000.
REQ-040 The bench SHALL check: the 64th s_clk rise and the s_pen rise detected in the same clk cycle -> data_valid and the full word accepted.
REQ-041 The bench SHALL check, with S2P_TIMEOUT_EN and TIMEOUT_CYCLES = 16: 10 pulses, then s_clk idle for 20 cycles -> frame_err, busy = 0; a later s_pen rise -> no pulse.
